// File: rtl/dt_skel.sv
// Medial-axis skeleton extractor: scans the distance map and packs local-maximum pixels 16 per word.
// Optional SKEL_CNT_EN adds skel_cnt, the saturating count of marked pixels in the current scan.
module dt_skel #(
    parameter int W_LOG2 = 7,
    parameter int PIX_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic                  res_rd,
    output logic [2*W_LOG2-1:0]   res_addr,
    input  logic [PIX_W-1:0]      res_di,
    output logic                  skl_wr,
    output logic [2*W_LOG2-5:0]   skl_addr,
    output logic [15:0]           skl_do,
`ifdef SKEL_CNT_EN
    output logic [2*W_LOG2-1:0]   skel_cnt,
`endif
    output logic [2:0]            dbg_state_o
);
    localparam int AW = 2 * W_LOG2;
    localparam logic [W_LOG2-1:0] ONE     = 1;
    localparam logic [AW-1:0]     PIX_ONE = 1;

    // Valid/ready: res_rd is a one-cycle request; res_di answers on the following cycle, no stall.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        C_REQ = 3'd1,
        C_CMP = 3'd2,
        N_REQ = 3'd3,
        N_CMP = 3'd4,
        SHIFT = 3'd5,
        WR    = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     pix_q, pix_d;
    logic [PIX_W-1:0]  center_q, center_d;
    logic [2:0]        k_q, k_d;
    logic              bit_q, bit_d;
    logic [15:0]       sreg_q, sreg_d;
    logic              done_q, done_d;
`ifdef SKEL_CNT_EN
    logic [AW-1:0]     cnt_q, cnt_d;
`endif

    logic [W_LOG2-1:0] row, col, nrow, ncol;
    logic [7:0]        nb_ok;
    logic [3:0]        first_nb, after_nb;

    // Lowest in-image neighbour index >= from; 8 means none left.
    function automatic logic [3:0] next_nb(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) r = 4'(i);
        end
        return r;
    endfunction

    assign row = pix_q[AW-1:W_LOG2];
    assign col = pix_q[W_LOG2-1:0];

    // Neighbour order N, NE, E, SE, S, SW, W, NW.
    always_comb begin
        logic top, bot, lft, rgt;
        top = (row == '0);
        bot = (row == '1);
        lft = (col == '0);
        rgt = (col == '1);
        nb_ok[0] = !top;
        nb_ok[1] = !top && !rgt;
        nb_ok[2] = !rgt;
        nb_ok[3] = !bot && !rgt;
        nb_ok[4] = !bot;
        nb_ok[5] = !bot && !lft;
        nb_ok[6] = !lft;
        nb_ok[7] = !top && !lft;
    end

    always_comb begin
        nrow = row;
        ncol = col;
        case (k_q)
            3'd0: nrow = row - ONE;
            3'd1: begin nrow = row - ONE; ncol = col + ONE; end
            3'd2: ncol = col + ONE;
            3'd3: begin nrow = row + ONE; ncol = col + ONE; end
            3'd4: nrow = row + ONE;
            3'd5: begin nrow = row + ONE; ncol = col - ONE; end
            3'd6: ncol = col - ONE;
            default: begin nrow = row - ONE; ncol = col - ONE; end
        endcase
    end

    assign first_nb = next_nb(nb_ok, 4'd0);
    assign after_nb = next_nb(nb_ok, 4'(k_q) + 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            center_q <= '0;
            k_q      <= '0;
            bit_q    <= 1'b0;
            sreg_q   <= '0;
            done_q   <= 1'b0;
`ifdef SKEL_CNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            center_q <= center_d;
            k_q      <= k_d;
            bit_q    <= bit_d;
            sreg_q   <= sreg_d;
            done_q   <= done_d;
`ifdef SKEL_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // k always points at an in-image neighbour, so the last comparison can finish the pixel directly.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        center_d = center_q;
        k_d      = k_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        done_d   = done_q;
`ifdef SKEL_CNT_EN
        cnt_d    = cnt_q;
`endif
        res_rd   = 1'b0;
        res_addr = '0;
        skl_wr   = 1'b0;
        skl_addr = '0;
        skl_do   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    pix_d   = '0;
                    sreg_d  = '0;
`ifdef SKEL_CNT_EN
                    cnt_d   = '0;
`endif
                    state_d = C_REQ;
                end
            end
            C_REQ: begin
                res_rd   = 1'b1;
                res_addr = pix_q;
                state_d  = C_CMP;
            end
            C_CMP: begin
                center_d = res_di;
                if (res_di == '0) begin
                    bit_d   = 1'b0;
                    state_d = SHIFT;
                end else if (first_nb[3]) begin
                    bit_d   = 1'b1;
                    state_d = SHIFT;
                end else begin
                    k_d     = first_nb[2:0];
                    state_d = N_REQ;
                end
            end
            N_REQ: begin
                res_rd   = 1'b1;
                res_addr = {nrow, ncol};
                state_d  = N_CMP;
            end
            N_CMP: begin
                if (res_di > center_q) begin
                    bit_d   = 1'b0;
                    state_d = SHIFT;
                end else if (after_nb[3]) begin
                    bit_d   = 1'b1;
                    state_d = SHIFT;
                end else begin
                    k_d     = after_nb[2:0];
                    state_d = N_REQ;
                end
            end
            SHIFT: begin
                sreg_d = {sreg_q[14:0], bit_q};
`ifdef SKEL_CNT_EN
                if (bit_q && (cnt_q != '1)) cnt_d = cnt_q + PIX_ONE;
`endif
                if (pix_q[3:0] == 4'hF) begin
                    state_d = WR;
                end else begin
                    pix_d   = pix_q + PIX_ONE;
                    state_d = C_REQ;
                end
            end
            WR: begin
                skl_wr   = 1'b1;
                skl_addr = pix_q[AW-1:4];
                skl_do   = sreg_q;
                if (pix_q == '1) begin
                    state_d = FIN;
                end else begin
                    pix_d   = pix_q + PIX_ONE;
                    state_d = C_REQ;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign done        = done_q;
    assign dbg_state_o = state_q;
`ifdef SKEL_CNT_EN
    assign skel_cnt    = cnt_q;
`endif

endmodule

// File: tb/tb_dt_skel.sv
// Directed bench for dt_skel on a 32x32 map (W_LOG2=5): 64 words per scan, 2 words per row.
// Expected word = row*2 + col/16, bit 15-(col%16); skel_cnt checked when SKEL_CNT_EN is defined.
module tb_dt_skel;
    localparam int W_LOG2 = 5;
    localparam int PIX_W  = 8;
    localparam int W      = 1 << W_LOG2;
    localparam int NPIX   = W * W;
    localparam int NWORDS = NPIX / 16;
    localparam int BOUND  = NPIX * 19 + NWORDS + 2;
    localparam logic [2:0] ST_CREQ = 3'd1;
    localparam logic [2:0] ST_NREQ = 3'd3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  done;
    logic                  res_rd;
    logic [2*W_LOG2-1:0]   res_addr;
    logic [PIX_W-1:0]      res_di = '0;
    logic                  skl_wr;
    logic [2*W_LOG2-5:0]   skl_addr;
    logic [15:0]           skl_do;
    logic [2:0]            dbg_state;
`ifdef SKEL_CNT_EN
    logic [2*W_LOG2-1:0]   skel_cnt;
`endif

    dt_skel #(.W_LOG2(W_LOG2), .PIX_W(PIX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .res_rd      (res_rd),
        .res_addr    (res_addr),
        .res_di      (res_di),
        .skl_wr      (skl_wr),
        .skl_addr    (skl_addr),
        .skl_do      (skl_do),
`ifdef SKEL_CNT_EN
        .skel_cnt    (skel_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- distance-map RAM model ----------------
    logic [7:0]  mem [0:NPIX-1];
    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_words [0:NWORDS-1];
    logic [15:0] exp_q [$];
    int          exp_addr = 0;
    int          wr_cnt   = 0;
    int          rises    = 0;
    int          bad_rd   = 0;
    int          ctr_addr = 0;
    logic        done_p   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write scoreboard, done-edge counter and read-address neighbourhood monitor.
    always @(negedge clk) begin
        if (!reset && skl_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_write", 32'(skl_addr), 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(skl_addr), 32'(exp_addr));
                check("wr_data", 32'(skl_do), 32'(exp_q.pop_front()));
                exp_addr++;
            end
        end
        if (done && !done_p) rises++;
        done_p = done;
        if (!reset && res_rd) begin
            if (dbg_state == ST_CREQ) begin
                ctr_addr = int'(res_addr);
            end else if (dbg_state == ST_NREQ) begin
                int dr, dc;
                dr = int'(res_addr) / W - ctr_addr / W;
                dc = int'(res_addr) % W - ctr_addr % W;
                if (dr < -1 || dr > 1 || dc < -1 || dc > 1 || (dr == 0 && dc == 0)) bad_rd++;
            end else begin
                bad_rd++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put(input int r, input int c, input logic [7:0] v);
        mem[r * W + c] = v;
    endtask

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        for (int i = 0; i < NWORDS; i++) exp_words[i] = 16'h0000;
    endtask

    // id 0: all zero; 1: single dot; 2: plateau with ring; 3: top-left border; 4: combined + far corners.
    task automatic load_img(input int id);
        clear_img();
        if (id == 1 || id == 4) begin
            put(5, 20, 8'd1);
            exp_words[11] = 16'h0800;
        end
        if (id == 2 || id == 4) begin
            for (int r = 9; r <= 12; r++)
                for (int c = 15; c <= 18; c++) put(r, c, 8'd1);
            put(10, 16, 8'd2); put(10, 17, 8'd2);
            put(11, 16, 8'd2); put(11, 17, 8'd2);
            exp_words[21] = 16'hC000;
            exp_words[23] = 16'hC000;
        end
        if (id == 3 || id == 4) begin
            put(0, 0, 8'd3); put(0, 1, 8'd2); put(1, 0, 8'd2); put(1, 1, 8'd1);
            exp_words[0] = 16'h8000;
        end
        if (id == 4) begin
            put(31, 31, 8'd5);
            put(31, 0, 8'd4);
            put(0, 31, 8'd200);
            exp_words[63] = 16'h0001;
            exp_words[62] = 16'h8000;
            exp_words[1]  = 16'h0001;
        end
    endtask

    task automatic load_exp();
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(exp_words[i]);
        exp_addr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full scan; restart_at > 0 pulses start again that many cycles into the scan.
    task automatic run_scan(input string tag, input int exp_cnt, input int restart_at);
        int w0, r0, cyc;
        load_exp();
        w0 = wr_cnt;
        r0 = rises;
        pulse_start();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
        end
        start = 1'b0;
        check({tag, "_done_in_bound"}, 32'(done), 32'd1);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(NWORDS));
        check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        check({tag, "_done_held"}, 32'(done), 32'd1);
        check({tag, "_done_rises"}, 32'(rises - r0), 32'd1);
        check({tag, "_bad_reads"}, 32'(bad_rd), 32'd0);
`ifdef SKEL_CNT_EN
        check({tag, "_skel_cnt"}, 32'(skel_cnt), 32'(exp_cnt));
`else
        if (exp_cnt < 0) $display("note: negative count for %s", tag);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},     32'(done),      32'd0);
        check({tag, "_res_rd"},   32'(res_rd),    32'd0);
        check({tag, "_res_addr"}, 32'(res_addr),  32'd0);
        check({tag, "_skl_wr"},   32'(skl_wr),    32'd0);
        check({tag, "_skl_addr"}, 32'(skl_addr),  32'd0);
        check({tag, "_skl_do"},   32'(skl_do),    32'd0);
        check({tag, "_state"},    32'(dbg_state), 32'd0);
`ifdef SKEL_CNT_EN
        check({tag, "_skel_cnt"}, 32'(skel_cnt),  32'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, cyc;
        reset = 1'b1;
        start = 1'b0;
        clear_img();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        load_img(0); run_scan("zero", 0, 0);
        load_img(1); run_scan("dot", 1, 0);
        load_img(2); run_scan("plateau", 4, 0);
        load_img(3); run_scan("border", 1, 0);

        // Reset partway through a scan (around pixel 300 of 1024).
        load_img(4);
        load_exp();
        w0 = wr_cnt;
        pulse_start();
        cyc = 0;
        while ((wr_cnt - w0) < 19 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("midscan_reached", 32'(wr_cnt - w0), 32'd19);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midscan_rst");
        w0 = wr_cnt;
        exp_q.delete();
        // start coinciding with reset must be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("post_rst_writes", 32'(wr_cnt - w0), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        run_scan("after_rst", 9, 0);
        run_scan("restart_ignored", 9, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dt_skel.md
Name: dt_skel

Overview:
- Downstream stage of the distance-transform engine. On `start`, it scans the 128x128 8-bit distance map held in the res RAM.
- It marks every pixel whose distance is non-zero and a local maximum of its 8-neighbourhood; these marked pixels form the medial-axis skeleton.
- Output is a packed binary image, 16 pixels per word, in the same 1024 x 16 format as the sti ROM.
- Runs after the DT asserts `done`.

Parameters:
- W_LOG2, 7, log2 of image width and height; the image is square. res_addr width = 2*W_LOG2; skl_addr width = 2*W_LOG2-4.
- PIX_W, 8, width of one distance value.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse to begin a scan; ignored while busy
- done  out  1  high once the scan completes; held until the next accepted start or reset
- res_rd  out  1  distance-map read request
- res_addr  out  14  pixel address = row*128 + col
- res_di  in  8  read data, valid the cycle after res_rd/res_addr
- skl_wr  out  1  skeleton word write strobe, one cycle
- skl_addr  out  10  word address = row*8 + col/16
- skl_do  out  16  packed skeleton word; bit 15-(col%16) = pixel col

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, pixel counter and shift register are cleared.
  - Reset mid-scan abandons the scan. The partial word is discarded and no write is issued.
- Scan order: raster order, row 0 col 0 through row 127 col 127. The pixel counter is 14 bits.
- Marking rule: pixel P is marked iff d(P) > 0 and d(P) >= d(Q) for all 8 neighbours Q.
  - Comparisons are unsigned PIX_W-bit.
  - An out-of-image neighbour counts as 0. No read is issued for it.
  - Equal plateaus are therefore all marked.
- FSM states:
  - IDLE: wait for start. On start, clear done and go to C_REQ.
  - C_REQ: res_rd=1, res_addr=center.
  - C_CMP: latch the center value.
    - If it is 0, the bit is 0; go to SHIFT.
    - Otherwise set k=0 and go to N_REQ.
  - N_REQ: find the next in-image neighbour index k in this order: N, NE, E, SE, S, SW, W, NW.
    - Issue res_rd for it.
    - If no in-image neighbour remains, the bit is 1; go to SHIFT.
  - N_CMP: compare the neighbour with the center.
    - If neighbour > center, the bit is 0; go to SHIFT (early exit).
    - Otherwise k++ and go to N_REQ.
  - SHIFT: shift the bit into the 16-bit shift register, MSB first.
    - If col%16==15, go to WR.
    - Else advance the pixel and go to C_REQ.
  - WR: skl_wr=1, skl_addr=pixel>>4, skl_do=register.
    - If pixel==16383, go to FIN.
    - Else advance the pixel and go to C_REQ.
  - FIN: done=1, then go to IDLE (done stays high).
- res_rd is high only in C_REQ/N_REQ cycles that issue a read. At most one read is outstanding.
- Word writes: exactly 1024 per scan, addresses 0..1023 ascending, each exactly once.
- res_wr is never driven; the block only reads res.
- Latency:
  - Per pixel: 3 cycles for a zero pixel, up to 19 cycles worst case.
  - Per scan: at most 16384*19 + 1024 + 2 cycles.
  - The bench checks the upper bound only, not an exact count.
- start while busy is ignored. start in the same cycle as reset is ignored (reset wins).

Optional Feature:
- Macro SKEL_CNT_EN.
- When defined:
  - Adds output port skel_cnt[13:0], the number of marked pixels in the current scan.
  - Cleared on reset and on an accepted start; incremented in SHIFT when the bit is 1.
  - Stable and valid while done=1.
  - Saturates at 16383.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- res all 0 -> 1024 writes of 0x0000 to addresses 0..1023 in order; done=1 and stays high; skel_cnt=0.
- Single d=1 at (row 5, col 20), rest 0 -> word 41 = 0x0800, all other words 0; skel_cnt=1.
- 2x2 plateau of value 2 at rows 10-11, cols 16-17, with surrounding 8-ring of 1s, rest 0 -> words 81 and 89 = 0xC000, all others 0 (the 1s are not marked); skel_cnt=4.
- Border pixel (0,0)=3, (0,1)=2, (1,0)=2, (1,1)=1 -> word 0 = 0x8000 (out-of-image neighbours treated as 0); no res_rd ever has a row or col outside 0..127.
- Assert reset at pixel ~5000 mid-scan -> all outputs 0 next cycle, no further writes; a new start then yields a complete correct 1024-word result.
- Pulse start again 100 cycles into a scan -> ignored; exactly 1024 writes; done rises once within the cycle bound.
